// File: rtl/sram_line_controller.sv
// Single-port asynchronous SRAM controller: byte-masked word writes and
// burst line reads, with an address window check against BASE_ADDR.
module sram_line_controller #(
  parameter int          DATA_W      = 32,
  parameter int          LINE_WORDS  = 2,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 17
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MEM_W_EN,
  input  logic                         MEM_R_EN,
  input  logic [31:0]                  address,
  input  logic [DATA_W-1:0]            writeData,
  input  logic [DATA_W/8-1:0]          byteEn,
  output logic                         ready,
  output logic                         err,
  output logic [LINE_WORDS*DATA_W-1:0] readData,
  output logic [SRAM_AW-1:0]           SRAM_ADDR,
  inout  wire  [DATA_W-1:0]            SRAM_DQ,
  output logic                         SRAM_WE_N,
  output logic                         SRAM_OE_N,
  output logic                         SRAM_CE_N,
  output logic [DATA_W/8-1:0]          SRAM_BE_N
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                         state_q, state_d;
  logic [DATA_W-1:0]              data_q, data_d;
  logic [BYTES-1:0]               be_q, be_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [LINE_WORDS*DATA_W-1:0]   read_data_q, read_data_d;
  logic [SRAM_AW-1:0]             sram_addr_q, sram_addr_d;
  logic                           err_q, err_d;

  logic [31:0]                    offset;
  logic [31:0]                    word_idx;
  logic                           out_of_range;
  logic [SRAM_AW-1:0]             idx_trunc;
  logic [SRAM_AW-1:0]             line_base;

  // Wrapping subtraction is harmless: addresses below BASE_ADDR are rejected separately.
  assign offset       = address - BASE_ADDR;
  assign word_idx     = offset >> OFF_W;
  assign out_of_range = (address < BASE_ADDR) || ((word_idx >> SRAM_AW) != 32'd0);
  assign idx_trunc    = word_idx[SRAM_AW-1:0];
  assign line_base    = idx_trunc & ~(SRAM_AW'(LINE_WORDS - 1));

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          data_d = writeData;
          be_d   = byteEn;
          cnt_d  = '0;
          if (out_of_range) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = WRITE;
            sram_addr_d = idx_trunc;
          end
        end else if (MEM_R_EN) begin
          cnt_d  = '0;
          beat_d = '0;
          if (out_of_range) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = READ;
            sram_addr_d = line_base;
          end
        end
      end
      WRITE: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          read_data_d[beat_q*DATA_W +: DATA_W] = SRAM_DQ;
          cnt_d = '0;
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            beat_d      = beat_q + BEAT_W'(1);
            sram_addr_d = sram_addr_q + SRAM_AW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      err_q       <= err_d;
    end
  end

  // Strobes decode straight from the state so an async reset releases the bus at once.
  always_comb begin
    ready     = (state_q == DONE) || ((state_q == IDLE) && !MEM_W_EN && !MEM_R_EN);
    SRAM_CE_N = !((state_q == WRITE) || (state_q == READ));
    SRAM_OE_N = (state_q != READ);
    SRAM_WE_N = !((state_q == WRITE) && (cnt_q < CNT_W'(WAIT_CYCLES)));
    if (state_q == WRITE) begin
      SRAM_BE_N = ~be_q;
    end else if (state_q == READ) begin
      SRAM_BE_N = '0;
    end else begin
      SRAM_BE_N = '1;
    end
  end

  assign err       = err_q;
  assign readData  = read_data_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_DQ   = (state_q == WRITE) ? data_q : {DATA_W{1'bz}};

endmodule

// File: doc/sram_line_controller.md
SRAM_LINE_CONTROLLER -- requirements
Module: sram_line_controller

Interface
REQ-001 Parameter DATA_W, default 32: CPU word and SRAM data width in bits; multiple of 8.
REQ-002 Parameter LINE_WORDS, default 2: words per read line; power of 2, at least 1.
REQ-003 Parameter WAIT_CYCLES, default 2: cycles per SRAM access; at least 1.
REQ-004 Parameter BASE_ADDR, default 1024: CPU byte address mapped to SRAM word 0.
REQ-005 Parameter SRAM_AW, default 17: SRAM word-address width.
REQ-006 Port clk  in  1: single clock; all state changes on rising edge.
REQ-007 Port rst  in  1: reset; asynchronous and active-high.
REQ-008 Port MEM_W_EN  in  1: write request.
REQ-009 Port MEM_R_EN  in  1: line read request.
REQ-010 Port address  in  32: CPU byte address.
REQ-011 Port writeData  in  DATA_W: write word.
REQ-012 Port byteEn  in  DATA_W/8: write byte-lane enables; bit i covers byte i.
REQ-013 Port ready  out  1: controller is free or the transaction is complete.
REQ-014 Port err  out  1: out-of-range access; valid when ready=1.
REQ-015 Port readData  out  LINE_WORDS*DATA_W: last line read; word k at bits [k*DATA_W +: DATA_W].
REQ-016 Port SRAM_ADDR  out  SRAM_AW: SRAM word address.
REQ-017 Port SRAM_DQ  inout  DATA_W: SRAM data bus.
REQ-018 Ports SRAM_WE_N, SRAM_OE_N, SRAM_CE_N  out  1 each: active-low strobes.
REQ-019 Port SRAM_BE_N  out  DATA_W/8: active-low byte enables.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, READ and DONE.
REQ-021 Word index SHALL be (address - BASE_ADDR) >> log2(DATA_W/8), computed in 32-bit unsigned arithmetic; low byte-offset bits SHALL be ignored.
REQ-022 Range check: the access SHALL be out of range when address < BASE_ADDR or word index >= 2^SRAM_AW.
REQ-023 In IDLE, MEM_W_EN=1 SHALL latch address, writeData and byteEn; the next state SHALL be WRITE, or DONE with err=1 if out of range.
REQ-024 In IDLE, MEM_R_EN=1 with MEM_W_EN=0 SHALL latch address; the next state SHALL be READ, or DONE with err=1 if out of range.
REQ-025 If MEM_W_EN and MEM_R_EN are both 1, the write SHALL take priority and the read SHALL be dropped.
REQ-026 Once a request is accepted, changes on the request inputs SHALL be ignored until DONE.
REQ-027 WRITE SHALL last WAIT_CYCLES+1 cycles:
- CE_N=0, OE_N=1.
- SRAM_DQ driven with the latched data.
- SRAM_BE_N = ~latched byteEn.
- WE_N=0 for the first WAIT_CYCLES cycles, and WE_N=1 in the final hold cycle.
REQ-028 READ SHALL perform LINE_WORDS beats of WAIT_CYCLES cycles each:
- CE_N=0, OE_N=0, WE_N=1, BE_N all 0.
- SRAM_DQ high-Z.
- Beat k (0..LINE_WORDS-1) uses SRAM_ADDR = (word index with low log2(LINE_WORDS) bits cleared) + k.
REQ-029 At the clock edge ending each beat, SRAM_DQ SHALL be sampled into readData word k.
REQ-030 readData SHALL change only on READ beat sampling; writes and errors SHALL leave it unchanged.
REQ-031 DONE SHALL last exactly 1 cycle with ready=1, then return to IDLE.
REQ-032 In IDLE, ready SHALL be 1 iff MEM_W_EN=0 and MEM_R_EN=0.
REQ-033 ready SHALL be 0 in WRITE and READ.
REQ-034 Latency: with acceptance at edge 0, write ready SHALL assert in cycle WAIT_CYCLES+2 and read ready in cycle LINE_WORDS*WAIT_CYCLES+1; defaults give 4 and 5.
REQ-035 An error access SHALL assert ready and err in cycle 1 with no SRAM strobes.
REQ-036 err SHALL be 0 outside an error DONE cycle.
REQ-037 Enables still held in IDLE after DONE SHALL start a new transaction.
REQ-038 Outside WRITE and READ: CE_N=1, OE_N=1, WE_N=1, BE_N all 1, SRAM_DQ high-Z, SRAM_ADDR holding its last value.
REQ-039 SRAM_DQ SHALL be driven only in WRITE cycles.

Reset
REQ-040 rst=1 SHALL immediately force:
- state IDLE, readData 0, SRAM_ADDR 0, err 0;
- all strobes high, BE_N all 1, SRAM_DQ high-Z.
REQ-041 Reset mid-WRITE or mid-READ SHALL abort the access with no further strobes.
REQ-042 After reset, ready SHALL follow REQ-032.

Verification
REQ-043 Defaults; write 0xDEADBEEF to 0x408, byteEn=0xF:
- SRAM_ADDR=2 and WE_N=0 for 2 cycles, DQ=0xDEADBEEF for 3 cycles;
- ready=1 in cycle 4, err=0.
REQ-044 Defaults; read 0x40C with SRAM words 2=0x11111111 and 3=0x22222222:
- SRAM_ADDR 2 then 3, ready in cycle 5;
- readData=0x22222222_11111111.
REQ-045 Write 0x400 with byteEn=0x5 -> SRAM_BE_N=0xA during WRITE.
REQ-046 Read at 0x3FC, and read at BASE_ADDR+4*2^17 -> ready=1 and err=1 in cycle 1, no strobes, readData unchanged.
REQ-047 MEM_W_EN=MEM_R_EN=1 -> write only; readData unchanged.
REQ-048 rst pulse during read beat 1 -> immediate IDLE, strobes high, DQ high-Z, readData=0; the next read completes normally.
